// File: rtl/mic_filter_pkg.sv
// ---------------------------------------------------------------------------
// mic_filter_pkg
// Shared constants and helpers for the microphone filter chain (CIC decimator
// and the downstream compensation FIR / half-band stages).
//   DEF_ORDER, DEF_LOG2_DECIM, DEF_OUT_BITS : default CIC / PCM geometry
//   cic_width(order, log2_decim)           : CIC accumulator width (bit growth + sign + margin)
//   sat_shift(value, shift, out_bits)      : arithmetic right shift, then clamp to a signed out_bits range
// ---------------------------------------------------------------------------
package mic_filter_pkg;

    localparam int DEF_ORDER      = 4;
    localparam int DEF_LOG2_DECIM = 6;
    localparam int DEF_OUT_BITS   = 16;

    // Bit growth of an ORDER-stage CIC with ratio 2^log2_decim is
    // order*log2_decim; two extra bits hold the sign of the +/-1 input and
    // the full-scale positive value without aliasing into the sign bit.
    function automatic int cic_width(input int order, input int log2_decim);
        return order * log2_decim + 2;
    endfunction

    // Returns the shifted value clamped to [-2^(out_bits-1), 2^(out_bits-1)-1],
    // still 64 bits wide; the caller truncates to out_bits.
    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] value,
                                                     input int                 shift,
                                                     input int                 out_bits);
        logic signed [63:0] shifted;
        logic signed [63:0] max_val;
        logic signed [63:0] min_val;
        shifted = value >>> shift;
        max_val = (64'sd1 <<< (out_bits - 1)) - 64'sd1;
        min_val = -(64'sd1 <<< (out_bits - 1));
        if (shifted > max_val) begin
            return max_val;
        end else if (shifted < min_val) begin
            return min_val;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// ---------------------------------------------------------------------------
// cic_comb_stage
// One strobe-qualified CIC comb section: dout = din - previous din (mod 2^W).
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   in_valid  : strobe qualifying din; the delay register only moves on it
//   din       : signed W-bit input sample
//   out_valid : in_valid delayed by one cycle
//   dout      : signed W-bit difference, held between strobes
// ---------------------------------------------------------------------------
module cic_comb_stage #(
    parameter int W = 26
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic signed [W-1:0] din,
    output logic                out_valid,
    output logic signed [W-1:0] dout
);

    logic signed [W-1:0] prev;

    // Difference and delay register advance together on the strobe only, so
    // the lag is one decimated sample rather than one clock. Wrapping
    // subtraction is intentional: it undoes the integrator wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev      <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                dout <= din - prev;
                prev <= din;
            end
        end
    end

endmodule

// File: rtl/pdm_cic_decimator.sv
// ---------------------------------------------------------------------------
// pdm_cic_decimator
// Hogenauer CIC decimator turning a 1-bit PDM stream into signed PCM.
// ORDER integrators at the PDM rate, decimation by 2^LOG2_DECIM, ORDER
// strobe-qualified combs, then arithmetic shift with saturation.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   pdm_in    : PDM bit (1 -> +1, 0 -> -1), sampled when pdm_valid is high
//   pdm_valid : one-cycle strobe per PDM bit, may be held high
//   pcm_out   : signed OUT_BITS PCM sample, held between strobes
//   pcm_valid : one-cycle strobe marking a new pcm_out
// Latency from the sampling of the last PDM bit of a frame to pcm_valid is
// ORDER+2 cycles: dec_strobe, capture register, ORDER combs, output register
// counted as dec_strobe + (capture + ORDER-1 comb pipeline slots) + output.
// ---------------------------------------------------------------------------
module pdm_cic_decimator
    import mic_filter_pkg::*;
#(
    parameter int ORDER      = DEF_ORDER,
    parameter int LOG2_DECIM = DEF_LOG2_DECIM,
    parameter int OUT_BITS   = DEF_OUT_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pdm_in,
    input  logic                       pdm_valid,
    output logic signed [OUT_BITS-1:0] pcm_out,
    output logic                       pcm_valid
);

    localparam int W     = cic_width(ORDER, LOG2_DECIM);
    localparam int SHIFT = W - 1 - OUT_BITS;
    localparam logic [LOG2_DECIM-1:0] PHASE_LAST = '1;

    logic signed [W-1:0]          pdm_mapped;
    logic signed [W-1:0]          integ [ORDER];
    logic [LOG2_DECIM-1:0]        phase;
    logic                         dec_strobe;
    logic signed [W-1:0]          cap_data;
    logic                         cap_valid;
    logic signed [W-1:0]          comb_data [ORDER+1];
    logic [ORDER:0]               comb_valid;
    logic signed [63:0]           comb_wide;

    assign pdm_mapped = pdm_in ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};

    // Pipelined integrator cascade: each stage adds the registered output of
    // the previous one. Overflow wraps on purpose; the combs cancel it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < ORDER; k++) begin
                integ[k] <= '0;
            end
        end else if (pdm_valid) begin
            integ[0] <= integ[0] + pdm_mapped;
            for (int k = 1; k < ORDER; k++) begin
                integ[k] <= integ[k] + integ[k-1];
            end
        end
    end

    // Phase counts accepted PDM bits; the last bit of each frame raises
    // dec_strobe for exactly the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase      <= '0;
            dec_strobe <= 1'b0;
        end else begin
            dec_strobe <= pdm_valid && (phase == PHASE_LAST);
            if (pdm_valid) begin
                phase <= phase + LOG2_DECIM'(1);
            end
        end
    end

    // Snapshot of the last integrator feeding the comb pipeline, so the
    // combs see a stable value even while integration continues.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_data  <= '0;
            cap_valid <= 1'b0;
        end else begin
            cap_valid <= dec_strobe;
            if (dec_strobe) begin
                cap_data <= integ[ORDER-1];
            end
        end
    end

    assign comb_data[0]  = cap_data;
    assign comb_valid[0] = cap_valid;

    for (genvar j = 0; j < ORDER; j++) begin : g_comb
        cic_comb_stage #(
            .W(W)
        ) u_comb (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (comb_valid[j]),
            .din       (comb_data[j]),
            .out_valid (comb_valid[j+1]),
            .dout      (comb_data[j+1])
        );
    end

    assign comb_wide = 64'(comb_data[ORDER]);

    // Output register: scale down to OUT_BITS with saturation, since a
    // full-scale stream of ones reaches exactly +2^(W-2), one LSB past the
    // largest positive PCM code after the shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
        end else begin
            pcm_valid <= comb_valid[ORDER];
            if (comb_valid[ORDER]) begin
                pcm_out <= OUT_BITS'(sat_shift(comb_wide, SHIFT, OUT_BITS));
            end
        end
    end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// ---------------------------------------------------------------------------
// tb_pdm_cic_decimator
// Directed bench for pdm_cic_decimator at default parameters
// (ORDER=4, R=64, W=26, SHIFT=9, OUT_BITS=16).
// ---------------------------------------------------------------------------
module tb_pdm_cic_decimator;

    localparam int R       = 64;
    localparam int LATENCY = 6;
    localparam int TRANS   = 4;

    localparam int MODE_ONES  = 0;
    localparam int MODE_ZEROS = 1;
    localparam int MODE_ALT   = 2;
    localparam int MODE_75    = 3;

    logic               clk;
    logic               rst;
    logic               pdm_in;
    logic               pdm_valid;
    logic signed [15:0] pcm_out;
    logic               pcm_valid;

    int cycle  = 0;
    int checks = 0;
    int errors = 0;
    int base   = 0;
    int first  = 0;

    logic signed [15:0] pcm_q[$];
    int                 time_q[$];

    pdm_cic_decimator dut (
        .clk       (clk),
        .rst       (rst),
        .pdm_in    (pdm_in),
        .pdm_valid (pdm_valid),
        .pcm_out   (pcm_out),
        .pcm_valid (pcm_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge counter used to timestamp input strobes and output pulses.
    always @(posedge clk) begin
        cycle <= cycle + 1;
    end

    // Records every pcm_valid pulse with its value and posedge count.
    always @(negedge clk) begin
        if (pcm_valid === 1'b1) begin
            pcm_q.push_back(pcm_out);
            time_q.push_back(cycle);
        end
    end

    function automatic logic patternBit(input int mode, input int idx);
        case (mode)
            MODE_ONES:  return 1'b1;
            MODE_ZEROS: return 1'b0;
            MODE_ALT:   return (idx % 2) == 0;
            default:    return (idx % 4) != 3;
        endcase
    endfunction

    function automatic logic signed [63:0] pcmAt(input int idx);
        if (base + idx < pcm_q.size()) begin
            return 64'(pcm_q[base + idx]);
        end
        return 'x;
    endfunction

    function automatic int timeAt(input int idx);
        if (base + idx < time_q.size()) begin
            return time_q[base + idx];
        end
        return -1;
    endfunction

    function automatic int pulseCount();
        return pcm_q.size() - base;
    endfunction

    task automatic checkOutput(input string tag,
                               input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst       = 1'b0;
        pdm_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst  = 1'b1;
        base = pcm_q.size();
    endtask

    // Drives n_bits PDM strobes, one every 'gap' cycles; idle cycles toggle
    // pdm_in so that any integration outside pdm_valid would show up.
    task automatic applyStimulus(input int n_bits, input int mode, input int gap,
                                 output int first_cycle);
        first_cycle = -1;
        for (int i = 0; i < n_bits; i++) begin
            @(negedge clk);
            if (i == 0) first_cycle = cycle;
            pdm_valid = 1'b1;
            pdm_in    = patternBit(mode, i);
            for (int g = 1; g < gap; g++) begin
                @(negedge clk);
                pdm_valid = 1'b0;
                pdm_in    = ~pdm_in;
            end
        end
        @(negedge clk);
        pdm_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        pdm_in    = 1'b1;
        pdm_valid = 1'b1;

        // Outputs must stay quiet while reset is held, even with strobes.
        repeat (5) @(negedge clk);
        checkOutput("reset_pcm_out", pcm_out, 0);
        checkOutput("reset_pcm_valid", pcm_valid, 0);
        checkOutput("reset_no_pulses", pcm_q.size(), 0);
        pdm_valid = 1'b0;
        rst       = 1'b1;

        $display("[TB] constant ones, continuous strobes");
        applyReset();
        applyStimulus(8 * R, MODE_ONES, 1, first);
        repeat (12) @(negedge clk);
        checkOutput("ones_count", pulseCount(), 8);
        checkOutput("ones_latency", timeAt(0), first + R + LATENCY);
        for (int i = 1; i < 8; i++) begin
            checkOutput($sformatf("ones_spacing_%0d", i), timeAt(i) - timeAt(i - 1), R);
        end
        for (int i = TRANS; i < 8; i++) begin
            checkOutput($sformatf("ones_value_%0d", i), pcmAt(i), 32767);
        end

        $display("[TB] constant zeros");
        applyReset();
        applyStimulus(6 * R, MODE_ZEROS, 1, first);
        repeat (12) @(negedge clk);
        checkOutput("zeros_count", pulseCount(), 6);
        checkOutput("zeros_value_4", pcmAt(4), -32768);
        checkOutput("zeros_value_5", pcmAt(5), -32768);

        $display("[TB] 50 percent density");
        applyReset();
        applyStimulus(6 * R, MODE_ALT, 1, first);
        repeat (12) @(negedge clk);
        checkOutput("alt_count", pulseCount(), 6);
        checkOutput("alt_value_4", pcmAt(4), 0);
        checkOutput("alt_value_5", pcmAt(5), 0);

        $display("[TB] sparse strobes, 75 percent density");
        applyReset();
        applyStimulus(6 * R, MODE_75, 3, first);
        repeat (12) @(negedge clk);
        checkOutput("sparse_count", pulseCount(), 6);
        checkOutput("sparse_latency", timeAt(0), first + 3 * (R - 1) + 1 + LATENCY);
        checkOutput("sparse_spacing", timeAt(5) - timeAt(4), 3 * R);
        checkOutput("sparse_value_4", pcmAt(4), 16384);
        checkOutput("sparse_value_5", pcmAt(5), 16384);

        $display("[TB] reset in mid-frame");
        applyReset();
        applyStimulus(6 * R + 30, MODE_ONES, 1, first);
        repeat (2) @(negedge clk);
        checkOutput("mid_count_before", pulseCount(), 6);
        checkOutput("mid_pcm_before", pcm_out, 32767);
        rst = 1'b0;
        #1;
        checkOutput("mid_pcm_cleared", pcm_out, 0);
        checkOutput("mid_valid_cleared", pcm_valid, 0);
        repeat (3) @(negedge clk);
        rst  = 1'b1;
        base = pcm_q.size();
        applyStimulus(2 * R, MODE_ONES, 1, first);
        repeat (12) @(negedge clk);
        checkOutput("mid_count_after", pulseCount(), 2);
        checkOutput("mid_latency_after", timeAt(0), first + R + LATENCY);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pdm_cic_decimator.md
# pdm_cic_decimator

Converts a 1-bit PDM bitstream into signed PCM samples with a CIC (Hogenauer) decimation filter: ORDER integrators, decimation by 2^LOG2_DECIM, ORDER combs, then a scaling shift with saturation. It sits directly downstream of the pdm modulator, or of a mic PDM pin, in the mic_full_filter chain. Its PCM output feeds the compensation FIR and half-band stages.

## Interface
- ORDER, default 4: number of integrator stages and comb stages; legal range 1..6.
- LOG2_DECIM, default 6: the decimation ratio R is 2^LOG2_DECIM, so 64 by default.
- OUT_BITS, default 16: width of the signed PCM output.
- W: derived, not overridable; W = ORDER*LOG2_DECIM + 2 internal accumulator bits.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- pdm_in  in  1  PDM bit; sampled only when pdm_valid is high.
- pdm_valid  in  1  one-cycle strobe per PDM bit; may be held high continuously.
- pcm_out  out  OUT_BITS  signed PCM sample.
- pcm_valid  out  1  one-cycle strobe marking a new pcm_out.

## Operation
- **Input mapping:** pdm_in=1 maps to +1 and pdm_in=0 maps to -1, as W-bit two's complement.
- **Integrators:**
  - All ORDER integrators update only on cycles where pdm_valid is high.
  - Stage 0 accumulates the mapped input.
  - Stage k accumulates the registered output of stage k-1.
  - Integrators are pipelined: one register per stage.
  - All integrator arithmetic wraps modulo 2^W, with no saturation. Wrap is required for correctness.
- **Phase counter:**
  - Width LOG2_DECIM; counts pdm_valid strobes from 0 to R-1, then wraps to 0.
  - On a pdm_valid cycle with phase==R-1, dec_strobe is set for exactly the next cycle.
- **Combs:**
  - On dec_strobe, the last integrator's value is captured into comb stage 0.
  - Comb stage j computes y = x - x_prev (modulo 2^W), then updates x_prev.
  - Each comb stage takes one cycle and fires on its own strobe, so the comb chain is a strobe-qualified pipeline.
  - Comb delay registers update only on their own strobe.
- **Output scaling:**
  - SHIFT = W - 1 - OUT_BITS.
  - pcm_out = saturate(comb_out >>> SHIFT), using an arithmetic shift.
  - Saturation clamps to the range [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1].
- **Transient after reset:**
  - The first ORDER decimated outputs are transient.
  - They are still emitted with pcm_valid high; downstream logic is responsible for discarding them.
- **Reset:**
  - Reset is asynchronous and active-low.
  - It clears all integrators, comb delay registers, the phase counter, dec_strobe, the comb strobes, pcm_out (to 0) and pcm_valid (to 0).
  - A reset asserted in mid-frame discards the partial frame. After release, counting restarts at phase 0.
- **pdm_valid during a comb flush:** integration continues unaffected, because the comb pipeline is independent.

## Timing
- **Latency:** pcm_valid rises exactly ORDER+2 cycles after the clk edge that sampled the decimating pdm_valid (the one with phase==R-1).
  - 1 cycle for dec_strobe.
  - ORDER cycles for the comb stages.
  - 1 cycle for the output register.
- **pcm_valid width:** always exactly one cycle, with one pulse per R accepted pdm_valid strobes.
- **Output rate:** at most one pcm_valid every R cycles. With pdm_valid held continuously high, the spacing is exactly R cycles.
- **Hold behaviour:** pcm_out holds its value between strobes.
- **Throughput:** there is no backpressure, and the downstream stage must accept every sample.

## Structure
- **Shared package mic_filter_pkg:**
  - function cic_width(order, log2_decim).
  - function sat_shift(value, shift, out_bits).
  - The default ORDER, LOG2_DECIM and OUT_BITS constants, shared with the downstream FIR.
- **Sub-module cic_comb_stage:**
  - Parameter W.
  - Ports: clk, rst, in_valid, din, out_valid, dout.
  - Instantiated ORDER times in a generate loop.
- **Top module:** keeps the integrators, the phase counter and the output saturation inline.

## Test plan
All scenarios use the defaults: ORDER=4, R=64, W=26, SHIFT=9, OUT_BITS=16.
- **Constant ones:** pdm_in=1 with pdm_valid continuous. After the transient, comb_out = +2^24, so pcm_out = 32767 (saturated). pcm_valid has a period of exactly 64 cycles.
- **Constant zeros:** pdm_in=0. After the transient, pcm_out = -32768.
- **50 % density:** alternating 1,0 bits, driven for example by pdm with din=128, NBITS=8. The steady-state pcm_out is within ±1 of 0.
- **Latency check:** first pdm_valid right after reset, with pdm_valid high every cycle. The first pcm_valid occurs 6 cycles after the 64th pdm_valid edge. pcm_out stays 0 and pcm_valid stays 0 throughout reset.
- **Sparse strobes:** pdm_valid every 3rd cycle with a 75 % density pattern. Output equals the continuous-strobe result (+2^24/2, i.e. ~16384). Cycles without pdm_valid must not change any integrator.
- **Reset mid-frame:** assert rst low at phase 30. All outputs go to 0 immediately. After release, the next pcm_valid arrives 64 strobes + 6 cycles later.
